// File: rtl/exe_stage.sv
// EXE pipeline stage: operand forwarding, single-cycle ALU, multicycle
// shift-add multiplier and the EX/MEM pipeline register (negedge clocked).
module exe_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic [1:0] WB_i,
  input  logic [5:0] MEM_i,
  input  logic [3:0] alu_code,
  input  logic       mux1,
  input  logic       mux2,
  input  logic [7:0] new_address_i,
  input  logic [7:0] Sign_i,
  input  logic [7:0] readA_i,
  input  logic [7:0] readB_i,
  input  logic [3:0] A_reg_i,
  input  logic [3:0] B_reg_i,
  input  logic [3:0] W_reg_i,
  input  logic       fwd_em_we,
  input  logic [3:0] fwd_em_reg,
  input  logic [7:0] fwd_em_data,
  input  logic       fwd_mw_we,
  input  logic [3:0] fwd_mw_reg,
  input  logic [7:0] fwd_mw_data,
  output logic       stall_o,
  output logic [1:0] WB_o,
  output logic [5:0] MEM_o,
  output logic [7:0] alu_result_o,
  output logic [7:0] store_data_o,
  output logic [3:0] W_reg_o,
  output logic [7:0] branch_target_o,
  output logic       zero_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;

  logic [1:0] state;
  logic [2:0] cnt;
  logic [7:0] acc, mcand, mplier;
  logic [1:0] hold_wb;
  logic [5:0] hold_mem;
  logic [3:0] hold_wreg;
  logic [7:0] hold_store, hold_bt;

  logic [7:0] fwd_a, fwd_b, op_a, op_b, alu_res, br_tgt;
  logic       mul_accept;

  logic [1:0] n_wb;
  logic [5:0] n_mem;
  logic [7:0] n_res, n_store, n_bt;
  logic [3:0] n_wreg;
  logic       n_zero;

  // EX/MEM has priority over MEM/WB; register 0 is never forwarded
  always_comb begin
    fwd_a = readA_i;
    if (fwd_em_we && (fwd_em_reg == A_reg_i) && (A_reg_i != 4'd0))
      fwd_a = fwd_em_data;
    else if (fwd_mw_we && (fwd_mw_reg == A_reg_i) && (A_reg_i != 4'd0))
      fwd_a = fwd_mw_data;
  end

  always_comb begin
    fwd_b = readB_i;
    if (fwd_em_we && (fwd_em_reg == B_reg_i) && (B_reg_i != 4'd0))
      fwd_b = fwd_em_data;
    else if (fwd_mw_we && (fwd_mw_reg == B_reg_i) && (B_reg_i != 4'd0))
      fwd_b = fwd_mw_data;
  end

  assign op_a   = mux1 ? new_address_i : fwd_a;
  assign op_b   = mux2 ? Sign_i : fwd_b;
  assign br_tgt = new_address_i + Sign_i;

  always_comb begin
    alu_res = '0;
    case (alu_code)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = ($signed(op_a) < $signed(op_b)) ? 8'd1 : 8'd0;
      OP_SHL:  alu_res = op_a << op_b[2:0];
      OP_SHR:  alu_res = op_a >> op_b[2:0];
      OP_PASS: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  assign mul_accept = (state == IDLE) && (alu_code == OP_MUL) && !flush_i;

  always_comb begin
    stall_o = 1'b0;
    if (rst_n) begin
      if (state == BUSY) stall_o = 1'b1;
      else if (mul_accept) stall_o = 1'b1;
    end
  end

  // Next EX/MEM contents; defaults form the bubble loaded while stalled or flushed
  always_comb begin
    n_wb    = '0;
    n_mem   = '0;
    n_res   = '0;
    n_store = '0;
    n_wreg  = '0;
    n_bt    = '0;
    n_zero  = 1'b0;
    if (!flush_i) begin
      if ((state == IDLE) && (alu_code != OP_MUL)) begin
        n_wb    = WB_i;
        n_mem   = MEM_i;
        n_res   = alu_res;
        n_store = fwd_b;
        n_wreg  = W_reg_i;
        n_bt    = br_tgt;
        n_zero  = (alu_res == 8'd0);
      end else if (state == DONE) begin
        n_wb    = hold_wb;
        n_mem   = hold_mem;
        n_res   = acc;
        n_store = hold_store;
        n_wreg  = hold_wreg;
        n_bt    = hold_bt;
        n_zero  = (acc == 8'd0);
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_o            <= '0;
      MEM_o           <= '0;
      alu_result_o    <= '0;
      store_data_o    <= '0;
      W_reg_o         <= '0;
      branch_target_o <= '0;
      zero_o          <= 1'b0;
    end else begin
      WB_o            <= n_wb;
      MEM_o           <= n_mem;
      alu_result_o    <= n_res;
      store_data_o    <= n_store;
      W_reg_o         <= n_wreg;
      branch_target_o <= n_bt;
      zero_o          <= n_zero;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      hold_wb    <= '0;
      hold_mem   <= '0;
      hold_wreg  <= '0;
      hold_store <= '0;
      hold_bt    <= '0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (alu_code == OP_MUL) begin
            mcand      <= op_a;
            mplier     <= op_b;
            acc        <= '0;
            cnt        <= '0;
            hold_wb    <= WB_i;
            hold_mem   <= MEM_i;
            hold_wreg  <= W_reg_i;
            hold_store <= fwd_b;
            hold_bt    <= br_tgt;
            state      <= BUSY;
          end
        end
        BUSY: begin
          acc    <= acc + (mplier[0] ? mcand : 8'd0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage; outputs sampled on posedge,
// away from the negedge at which the stage updates.
module tb_exe_stage;
  logic       clk = 1'b0;
  logic       rst_n, flush_i, mux1, mux2;
  logic [1:0] WB_i;
  logic [5:0] MEM_i;
  logic [3:0] alu_code, A_reg_i, B_reg_i, W_reg_i;
  logic [7:0] new_address_i, Sign_i, readA_i, readB_i;
  logic       fwd_em_we, fwd_mw_we;
  logic [3:0] fwd_em_reg, fwd_mw_reg;
  logic [7:0] fwd_em_data, fwd_mw_data;
  logic       stall_o, zero_o;
  logic [1:0] WB_o;
  logic [5:0] MEM_o;
  logic [7:0] alu_result_o, store_data_o, branch_target_o;
  logic [3:0] W_reg_o;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .WB_i(WB_i), .MEM_i(MEM_i),
    .alu_code(alu_code), .mux1(mux1), .mux2(mux2), .new_address_i(new_address_i),
    .Sign_i(Sign_i), .readA_i(readA_i), .readB_i(readB_i), .A_reg_i(A_reg_i),
    .B_reg_i(B_reg_i), .W_reg_i(W_reg_i), .fwd_em_we(fwd_em_we),
    .fwd_em_reg(fwd_em_reg), .fwd_em_data(fwd_em_data), .fwd_mw_we(fwd_mw_we),
    .fwd_mw_reg(fwd_mw_reg), .fwd_mw_data(fwd_mw_data), .stall_o(stall_o),
    .WB_o(WB_o), .MEM_o(MEM_o), .alu_result_o(alu_result_o),
    .store_data_o(store_data_o), .W_reg_o(W_reg_o),
    .branch_target_o(branch_target_o), .zero_o(zero_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one negedge (state update), then sample at the following posedge
  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic set_op(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b);
    alu_code = code; readA_i = a; readB_i = b;
    mux1 = 1'b0; mux2 = 1'b0; A_reg_i = 4'd1; B_reg_i = 4'd2;
    fwd_em_we = 1'b0; fwd_mw_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; WB_i = 2'b00; MEM_i = '0;
    new_address_i = '0; Sign_i = '0; W_reg_i = '0;
    fwd_em_reg = '0; fwd_em_data = '0; fwd_mw_reg = '0; fwd_mw_data = '0;
    set_op(4'd0, 8'd0, 8'd0);
    #1;
    chk("reset_result", {8'h0, alu_result_o}, 16'h0000);
    chk("reset_wb_mem", {8'h0, WB_o, MEM_o}, 16'h0000);
    chk("reset_stall", {15'h0, stall_o}, 16'h0000);
    @(posedge clk);
    rst_n = 1'b1;

    // plain ADD
    set_op(4'd0, 8'h05, 8'h03); W_reg_i = 4'd4; WB_i = 2'b01; MEM_i = 6'h2A;
    #1 chk("add_stall", {15'h0, stall_o}, 16'h0000);
    step();
    chk("add_result", {8'h0, alu_result_o}, 16'h0008);
    chk("add_zero", {15'h0, zero_o}, 16'h0000);
    chk("add_ctrl", {4'h0, W_reg_o, WB_o, MEM_o}, 16'h046A);
    chk("add_store", {8'h0, store_data_o}, 16'h0003);

    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 chk("async_rst_result", {8'h0, alu_result_o}, 16'h0000);
    chk("async_rst_ctrl", {4'h0, W_reg_o, WB_o, MEM_o}, 16'h0000);
    @(posedge clk) rst_n = 1'b1;

    // dual-match forwarding: EX/MEM wins
    set_op(4'd0, 8'h55, 8'h00); A_reg_i = 4'd3; B_reg_i = 4'd5;
    fwd_em_we = 1'b1; fwd_em_reg = 4'd3; fwd_em_data = 8'h11;
    fwd_mw_we = 1'b1; fwd_mw_reg = 4'd3; fwd_mw_data = 8'h22;
    step();
    chk("fwd_dual", {8'h0, alu_result_o}, 16'h0011);
    fwd_em_we = 1'b0;
    step();
    chk("fwd_mw_only", {8'h0, alu_result_o}, 16'h0022);
    fwd_em_we = 1'b1; A_reg_i = 4'd0;
    step();
    chk("fwd_r0", {8'h0, alu_result_o}, 16'h0055);
    B_reg_i = 4'd3; fwd_em_we = 1'b0; alu_code = 4'd9;
    step();
    chk("fwd_b_store", {8'h0, store_data_o}, 16'h0022);
    chk("pass_b", {8'h0, alu_result_o}, 16'h0022);

    // branch target wrap and immediate operand
    set_op(4'd0, 8'h10, 8'h00); mux2 = 1'b1; new_address_i = 8'hFE; Sign_i = 8'h05;
    step();
    chk("branch_wrap", {8'h0, branch_target_o}, 16'h0003);
    chk("add_imm", {8'h0, alu_result_o}, 16'h0015);
    mux1 = 1'b1;
    step();
    chk("add_pc_imm", {8'h0, alu_result_o}, 16'h0003);

    set_op(4'd5, 8'h80, 8'h01);
    step();
    chk("slt_signed", {8'h0, alu_result_o}, 16'h0001);
    set_op(4'd1, 8'h07, 8'h07);
    step();
    chk("sub_zero_res", {8'h0, alu_result_o}, 16'h0000);
    chk("sub_zero_flag", {15'h0, zero_o}, 16'h0001);
    set_op(4'd6, 8'h81, 8'h0B);
    step();
    chk("shl", {8'h0, alu_result_o}, 16'h0008);
    set_op(4'd7, 8'h81, 8'h0F);
    step();
    chk("shr", {8'h0, alu_result_o}, 16'h0001);
    set_op(4'd4, 8'hF0, 8'h3C);
    step();
    chk("xor", {8'h0, alu_result_o}, 16'h00CC);
    set_op(4'd12, 8'hF0, 8'h3C);
    step();
    chk("undef_code", {8'h0, alu_result_o}, 16'h0000);

    // MUL 0x0D * 0x0B with A forwarded; forward source changes mid-multiply
    set_op(4'd8, 8'h00, 8'h0B); A_reg_i = 4'd3;
    fwd_em_we = 1'b1; fwd_em_reg = 4'd3; fwd_em_data = 8'h0D;
    W_reg_i = 4'd9; WB_i = 2'b01; MEM_i = 6'h05;
    #1;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("mul_stall_%0d", i), {15'h0, stall_o}, 16'h0001);
      step();
      chk($sformatf("mul_bubble_%0d", i), {WB_o, MEM_o, alu_result_o}, 16'h0000);
      if (i == 1) fwd_em_data = 8'h77;
    end
    chk("mul_done_stall", {15'h0, stall_o}, 16'h0000);
    step();
    chk("mul_result", {8'h0, alu_result_o}, 16'h008F);
    chk("mul_ctrl", {4'h0, W_reg_o, WB_o, MEM_o}, 16'h0945);

    // back-to-back MUL 0xFF * 0xFF accepted the cycle after DONE
    set_op(4'd8, 8'hFF, 8'hFF); W_reg_i = 4'd2;
    #1 chk("b2b_accept_stall", {15'h0, stall_o}, 16'h0001);
    for (int i = 0; i < 9; i++) step();
    chk("b2b_done_stall", {15'h0, stall_o}, 16'h0000);
    step();
    chk("mul_ovf", {8'h0, alu_result_o}, 16'h0001);
    chk("mul_ovf_zero", {15'h0, zero_o}, 16'h0000);

    // flush during BUSY cycle 4
    set_op(4'd8, 8'h03, 8'h04);
    for (int i = 0; i < 4; i++) step();
    chk("abort_busy_stall", {15'h0, stall_o}, 16'h0001);
    flush_i = 1'b1;
    step();
    chk("abort_bubble", {WB_o, MEM_o, alu_result_o}, 16'h0000);
    flush_i = 1'b0; set_op(4'd0, 8'h21, 8'h12); WB_i = 2'b11;
    #1 chk("abort_stall_clear", {15'h0, stall_o}, 16'h0000);
    step();
    chk("abort_then_add", {8'h0, alu_result_o}, 16'h0033);

    // flush coinciding with a MUL accept
    set_op(4'd8, 8'h03, 8'h04); flush_i = 1'b1;
    #1 chk("flush_accept_stall", {15'h0, stall_o}, 16'h0000);
    step();
    chk("flush_accept_bubble", {WB_o, MEM_o, alu_result_o}, 16'h0000);
    flush_i = 1'b0; set_op(4'd3, 8'h50, 8'h05);
    step();
    chk("flush_then_or", {8'h0, alu_result_o}, 16'h0055);

    // reset mid-multiply, then a clean restart
    set_op(4'd8, 8'h03, 8'h04);
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 1'b0;
    #1 chk("rst_busy_stall", {15'h0, stall_o}, 16'h0000);
    chk("rst_busy_out", {WB_o, MEM_o, alu_result_o}, 16'h0000);
    @(posedge clk) rst_n = 1'b1;
    set_op(4'd2, 8'h3C, 8'h0F);
    #1 chk("post_rst_stall", {15'h0, stall_o}, 16'h0000);
    step();
    chk("post_rst_and", {8'h0, alu_result_o}, 16'h000C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout compared=%0d required=finish", compared);
    $fatal(1, "timeout");
  end
endmodule
